packet_picker: RTL and testbench



---
 rtl/packet_picker_if.sv | 26 ++
 rtl/packet_picker.sv | 141 ++++++++++++++
 tb/tb_packet_picker.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/packet_picker_if.sv
// Bus between the audio sample source / hdmi core and packet_picker.
// The slave side is the scheduler; the master side is its environment.
interface packet_picker_if #(
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int FIFO_DEPTH      = 16
);
  logic                                  frame_start;
  logic                                  packet_enable;
  logic                                  sample_valid;
  logic [1:0][AUDIO_BIT_WIDTH-1:0]       sample_in;
  logic [7:0]                            packet_type;
  logic [3:0][1:0][AUDIO_BIT_WIDTH-1:0]  sample_word;
  logic [3:0]                            sample_present;
  logic [$clog2(FIFO_DEPTH):0]           fifo_level;
  logic                                  overflow;

  modport master (
    output frame_start, packet_enable, sample_valid, sample_in,
    input  packet_type, sample_word, sample_present, fifo_level, overflow
  );

  modport slave (
    input  frame_start, packet_enable, sample_valid, sample_in,
    output packet_type, sample_word, sample_present, fifo_level, overflow
  );
endinterface

// File: rtl/packet_picker.sv
// Data-island packet scheduler: ACR, then (AVI when PACKET_PICKER_AVI_EN is
// defined), then Audio InfoFrame once per frame, then queued audio samples, else Null.
module packet_picker #(
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic           clk_pixel,
  input  logic           reset,
  packet_picker_if.slave bus
);
  localparam int LW = $clog2(FIFO_DEPTH);
  localparam logic [LW:0] DEPTH_L = (LW+1)'(FIFO_DEPTH);
  localparam logic [LW:0] FOUR_L  = (LW+1)'(4);
  localparam logic [7:0]  PT_NULL  = 8'h00;
  localparam logic [7:0]  PT_ACR   = 8'h01;
  localparam logic [7:0]  PT_AUDIO = 8'h02;
  localparam logic [7:0]  PT_AIF   = 8'h84;
`ifdef PACKET_PICKER_AVI_EN
  localparam logic [7:0]  PT_AVI   = 8'h82;
`endif

  typedef logic [1:0][AUDIO_BIT_WIDTH-1:0] frame_t;

  frame_t                              r_mem [FIFO_DEPTH];
  logic [LW-1:0]                       r_rd_ptr, r_wr_ptr;
  logic [LW:0]                         r_level;
  logic                                r_overflow;
  logic                                r_acr_sent, r_aif_sent;
  logic [7:0]                          r_packet_type;
  logic [3:0][1:0][AUDIO_BIT_WIDTH-1:0] r_sample_word;
  logic [3:0]                          r_sample_present;

  logic                                w_acr_sent, w_aif_sent;
  logic [7:0]                          w_type;
  logic [2:0]                          w_pop_n;
  logic                                w_push;
  logic [3:0][1:0][AUDIO_BIT_WIDTH-1:0] w_words;
  logic [3:0]                          w_present;

  // frame_start clears the flags before this cycle's slot decision sees them
  assign w_acr_sent = r_acr_sent & ~bus.frame_start;
  assign w_aif_sent = r_aif_sent & ~bus.frame_start;

`ifdef PACKET_PICKER_AVI_EN
  logic r_avi_sent;
  logic w_avi_sent;
  assign w_avi_sent = r_avi_sent & ~bus.frame_start;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_avi_sent <= 1'b0;
    end else begin
      r_avi_sent <= w_avi_sent | (bus.packet_enable & (w_type == PT_AVI));
    end
  end
`endif

  always_comb begin
    w_type  = PT_NULL;
    w_pop_n = 3'd0;
    if (!w_acr_sent) begin
      w_type = PT_ACR;
`ifdef PACKET_PICKER_AVI_EN
    end else if (!w_avi_sent) begin
      w_type = PT_AVI;
`endif
    end else if (!w_aif_sent) begin
      w_type = PT_AIF;
    end else if (r_level != '0) begin
      w_type = PT_AUDIO;
      if (bus.packet_enable) begin
        w_pop_n = (r_level > FOUR_L) ? 3'd4 : r_level[2:0];
      end else begin
        w_pop_n = 3'd0;
      end
    end else begin
      w_type = PT_NULL;
    end
  end

  always_comb begin
    w_words   = '0;
    w_present = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < w_pop_n) begin
        w_words[k]   = r_mem[r_rd_ptr + LW'(k)];
        w_present[k] = 1'b1;
      end else begin
        w_words[k]   = '0;
        w_present[k] = 1'b0;
      end
    end
  end

  // Space freed by this cycle's pop is available to a same-cycle push
  assign w_push = bus.sample_valid & ~((r_level == DEPTH_L) & (w_pop_n == 3'd0));

  always_ff @(posedge clk_pixel) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.sample_in;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_rd_ptr         <= '0;
      r_wr_ptr         <= '0;
      r_level          <= '0;
      r_overflow       <= 1'b0;
      r_acr_sent       <= 1'b0;
      r_aif_sent       <= 1'b0;
      r_packet_type    <= PT_NULL;
      r_sample_word    <= '0;
      r_sample_present <= 4'b0000;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + LW'(1);
      end
      r_rd_ptr <= r_rd_ptr + LW'(w_pop_n);
      r_level  <= r_level + (LW+1)'(w_push) - (LW+1)'(w_pop_n);
      if (bus.sample_valid && !w_push) begin
        r_overflow <= 1'b1;
      end
      r_acr_sent <= w_acr_sent | (bus.packet_enable & (w_type == PT_ACR));
      r_aif_sent <= w_aif_sent | (bus.packet_enable & (w_type == PT_AIF));
      if (bus.packet_enable) begin
        r_packet_type    <= w_type;
        r_sample_present <= w_present;
        if (w_type == PT_AUDIO) begin
          r_sample_word <= w_words;
        end
      end
    end
  end

  assign bus.packet_type    = r_packet_type;
  assign bus.sample_word    = r_sample_word;
  assign bus.sample_present = r_sample_present;
  assign bus.fifo_level     = r_level;
  assign bus.overflow       = r_overflow;
endmodule

// File: tb/tb_packet_picker.sv
// Randomised and directed bench for packet_picker against a queue-based reference model.
module tb_packet_picker;
  localparam int W     = 16;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  packet_picker_if #(.AUDIO_BIT_WIDTH(W), .FIFO_DEPTH(DEPTH)) bus ();

  packet_picker #(.AUDIO_BIT_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
    .clk_pixel (clk),
    .reset     (rst),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  string phase = "init";

  logic [31:0]  m_q[$];
  logic         m_acr, m_aif, m_avi, m_ovf;
  logic [7:0]   m_type;
  logic [3:0]   m_present;
  logic [127:0] m_words;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s.%s: got %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_acr = 1'b0; m_aif = 1'b0; m_avi = 1'b0; m_ovf = 1'b0;
    m_type = 8'h00; m_present = 4'b0000; m_words = '0;
  endtask

  task automatic model_step(input logic fs, input logic pe, input logic sv, input logic [31:0] s);
    int n;
    if (fs) begin
      m_acr = 1'b0; m_aif = 1'b0; m_avi = 1'b0;
    end
    if (pe) begin
      m_present = 4'b0000;
      if (!m_acr) begin
        m_type = 8'h01; m_acr = 1'b1;
`ifdef PACKET_PICKER_AVI_EN
      end else if (!m_avi) begin
        m_type = 8'h82; m_avi = 1'b1;
`endif
      end else if (!m_aif) begin
        m_type = 8'h84; m_aif = 1'b1;
      end else if (m_q.size() > 0) begin
        n = (m_q.size() < 4) ? m_q.size() : 4;
        m_words = '0;
        for (int i = 0; i < n; i++) begin
          m_words[32*i +: 32] = m_q.pop_front();
          m_present[i] = 1'b1;
        end
        m_type = 8'h02;
      end else begin
        m_type = 8'h00;
      end
    end
    if (sv) begin
      if (m_q.size() < DEPTH) m_q.push_back(s);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic compare_all();
    check_eq("ptype",   bus.packet_type, m_type);
    check_eq("present", bus.sample_present, m_present);
    check_eq("word",    bus.sample_word, m_words);
    check_eq("level",   bus.fifo_level, m_q.size());
    check_eq("ovf",     bus.overflow, m_ovf);
  endtask

  task automatic cyc(input logic fs, input logic pe, input logic sv, input logic [31:0] s);
    bus.frame_start   = fs;
    bus.packet_enable = pe;
    bus.sample_valid  = sv;
    bus.sample_in     = s;
    @(posedge clk);
    model_step(fs, pe, sv, s);
    #1;
    compare_all();
    bus.frame_start   = 1'b0;
    bus.packet_enable = 1'b0;
    bus.sample_valid  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
    cyc(1'b0, 1'b0, 1'b1, {r, l});
  endtask

  initial begin
    bus.frame_start   = 1'b0;
    bus.packet_enable = 1'b0;
    bus.sample_valid  = 1'b0;
    bus.sample_in     = '0;
    #1;

    phase = "reset";
    do_reset();

    phase = "empty";
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    for (int p = 0; p < 4; p++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      idle(2);
    end

    phase = "six";
    for (int i = 0; i < 6; i++) push_frame(16'(i), 16'(100 + i));
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    idle(1);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    idle(1);

    phase = "fill";
    for (int i = 0; i < 17; i++) push_frame(16'(200 + i), 16'(300 + i));
    idle(1);

    phase = "full_pop_push";
    cyc(1'b0, 1'b1, 1'b1, {16'd999, 16'd888});
    idle(1);

    phase = "fs_pe";
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    idle(1);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    idle(1);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
`ifdef PACKET_PICKER_AVI_EN
    idle(1);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
`endif
    idle(1);

    phase = "mid_reset";
    do_reset();
    for (int p = 0; p < 3; p++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      idle(1);
    end

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1, $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
